// File: rtl/full_st0_out_ctrl_data_tx.sv
// full_st0_out_ctrl_data_tx: buffers pipeline results into slots and replays
// each completed slot downstream as a first/last-flagged ready/valid burst.
module full_st0_out_ctrl_data_tx #(
    parameter int DATA_W = 32,
    parameter int WORD_W = 3,
    parameter int SLOT_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] load_length,
    input  logic [SLOT_W-1:0] load_depth,
    input  logic              result_vld,
    input  logic [DATA_W-1:0] result_data,
    output logic              result_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_fst,
    output logic              out_lst,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [SLOT_W:0]   occupancy,
    output logic              tx_busy
);
    typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

    logic [DATA_W-1:0] mem [2**(SLOT_W+WORD_W)];
    state_t            state;
    logic [WORD_W-1:0] wr_word, rd_word;
    logic [SLOT_W-1:0] wr_slot, rd_slot;
    logic [SLOT_W:0]   capacity;
    logic              accept, complete, rel, load;

    assign capacity   = {1'b0, load_depth} + (SLOT_W+1)'(1);
    assign result_rdy = occupancy != capacity;
    assign accept     = result_vld & result_rdy;
    assign complete   = accept & (wr_word == load_length);
    assign rel        = (state == DRAIN) & out_vld & out_rdy & out_lst;
    // rd_word is 0 whenever IDLE, so one load path serves both IDLE and SEND
    assign load       = (state == IDLE && occupancy != '0) || (state == SEND && out_rdy);
    assign tx_busy    = state != IDLE;

    always_ff @(posedge clk)
        if (accept) mem[{wr_slot, wr_word}] <= result_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_word   <= '0;
            wr_slot   <= '0;
            occupancy <= '0;
        end else begin
            if (accept) wr_word <= complete ? '0 : wr_word + 1'b1;
            if (complete) wr_slot <= (wr_slot == load_depth) ? '0 : wr_slot + 1'b1;
            occupancy <= occupancy + (SLOT_W+1)'(complete) - (SLOT_W+1)'(rel);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rd_word  <= '0;
            rd_slot  <= '0;
            out_data <= '0;
            out_fst  <= 1'b0;
            out_lst  <= 1'b0;
            out_vld  <= 1'b0;
        end else begin
            if (load) begin
                out_data <= mem[{rd_slot, rd_word}];
                out_fst  <= rd_word == '0;
                out_lst  <= rd_word == load_length;
                out_vld  <= 1'b1;
                rd_word  <= rd_word + 1'b1;
                state    <= (rd_word == load_length) ? DRAIN : SEND;
            end
            if (rel) begin
                out_vld <= 1'b0;
                rd_word <= '0;
                rd_slot <= (rd_slot == load_depth) ? '0 : rd_slot + 1'b1;
                state   <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_full_st0_out_ctrl_data_tx.sv
// tb_full_st0_out_ctrl_data_tx: directed bench for the stage output data transmitter.
module tb_full_st0_out_ctrl_data_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  load_length = '0;
    logic [2:0]  load_depth = '0;
    logic        result_vld = 1'b0;
    logic [31:0] result_data = '0;
    logic        result_rdy;
    logic [31:0] out_data;
    logic        out_fst, out_lst, out_vld;
    logic        out_rdy = 1'b0;
    logic [3:0]  occupancy;
    logic        tx_busy;

    int total = 0;
    int bad = 0;
    logic [33:0] q[$];
    logic        hold = 1'b0;
    logic [33:0] held = '0;
    int          mw = 0;
    int          mocc = 0;
    int          both_cnt = 0;
    int          b0;
    bit          done = 0;
    logic        cmp, rel;

    always #5 clk = ~clk;

    full_st0_out_ctrl_data_tx dut (
        .clk(clk), .reset(reset), .load_length(load_length), .load_depth(load_depth),
        .result_vld(result_vld), .result_data(result_data), .result_rdy(result_rdy),
        .out_data(out_data), .out_fst(out_fst), .out_lst(out_lst), .out_vld(out_vld),
        .out_rdy(out_rdy), .occupancy(occupancy), .tx_busy(tx_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        int n = 0;
        result_vld = 1'b1;
        result_data = d;
        while (!result_rdy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("push_wait", 64'(n < 3000), 1);
        @(negedge clk);
        result_vld = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while ((occupancy != 0 || tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n < 3000), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        result_vld = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q.delete();
    endtask

    // Independent occupancy model, transfer log and stall-stability checks
    assign cmp = result_vld && result_rdy && (mw == int'(load_length));
    assign rel = out_vld && out_rdy && out_lst;

    always @(posedge clk) begin
        if (reset) begin
            mw   <= 0;
            mocc <= 0;
            hold <= 1'b0;
        end else begin
            chk("occupancy_model", 64'(occupancy), 64'(mocc));
            if (hold) begin
                chk("stall_vld", 64'(out_vld), 1);
                chk("stall_word", {30'b0, out_fst, out_lst, out_data}, {30'b0, held});
            end
            if (out_vld && out_rdy) q.push_back({out_fst, out_lst, out_data});
            if (result_vld && result_rdy) mw <= cmp ? 0 : mw + 1;
            mocc <= mocc + int'(cmp) - int'(rel);
            if (cmp && rel) both_cnt <= both_cnt + 1;
            hold <= out_vld && !out_rdy;
            held <= {out_fst, out_lst, out_data};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: single 4-word burst, reset state and latency
        load_length = 3'd3;
        load_depth = 3'd1;
        do_reset();
        chk("rst_vld", 64'(out_vld), 0);
        chk("rst_fst", 64'(out_fst), 0);
        chk("rst_lst", 64'(out_lst), 0);
        chk("rst_data", 64'(out_data), 0);
        chk("rst_occ", 64'(occupancy), 0);
        chk("rst_busy", 64'(tx_busy), 0);
        chk("rst_rdy", 64'(result_rdy), 1);
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h10 + i);
        chk("t1_occ_after_fill", 64'(occupancy), 1);
        chk("t1_vld_latency", 64'(out_vld), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_vld", 64'(out_vld), 1);
            chk("t1_data", 64'(out_data), 64'(32'h10 + k));
            chk("t1_fst", 64'(out_fst), 64'(k == 0));
            chk("t1_lst", 64'(out_lst), 64'(k == 3));
        end
        @(negedge clk);
        chk("t1_vld_end", 64'(out_vld), 0);
        chk("t1_occ_end", 64'(occupancy), 0);
        chk("t1_busy_end", 64'(tx_busy), 0);
        chk("t1_count", 64'(q.size()), 4);

        // Test 2: backpressure fills both slots, release reopens the write side
        load_length = 3'd1;
        load_depth = 3'd1;
        out_rdy = 1'b0;
        do_reset();
        for (int i = 1; i <= 4; i++) push(32'(i));
        chk("t2_occ_full", 64'(occupancy), 2);
        chk("t2_rdy_low", 64'(result_rdy), 0);
        result_vld = 1'b1;
        result_data = 32'd5;
        repeat (3) @(negedge clk);
        chk("t2_held_occ", 64'(occupancy), 2);
        chk("t2_held_rdy", 64'(result_rdy), 0);
        chk("t2_stall_data", 64'(out_data), 1);
        chk("t2_stall_fst", 64'(out_fst), 1);
        out_rdy = 1'b1;
        @(negedge clk);
        chk("t2_lst_data", 64'(out_data), 2);
        chk("t2_lst_flag", 64'(out_lst), 1);
        chk("t2_rdy_still_low", 64'(result_rdy), 0);
        @(negedge clk);
        chk("t2_rdy_back", 64'(result_rdy), 1);
        chk("t2_occ_rel", 64'(occupancy), 1);
        chk("t2_bubble", 64'(out_vld), 0);
        @(negedge clk);
        push(32'd6);
        wait_empty("t2_drain");
        chk("t2_count", 64'(q.size()), 6);
        for (int i = 0; i < 6; i++)
            chk("t2_word", 64'(q[i]), {30'b0, i % 2 == 0, i % 2 == 1, 32'(i + 1)});

        // Test 3: random downstream stalls over 16 eight-word bursts
        load_length = 3'd7;
        load_depth = 3'd3;
        do_reset();
        fork
            begin
                for (int i = 0; i < 128; i++) push(32'hA000 + i);
                wait_empty("t3_drain");
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        out_rdy = 1'b1;
        chk("t3_count", 64'(q.size()), 128);
        for (int i = 0; i < 128; i++)
            chk("t3_word", 64'(q[i]), {30'b0, i % 8 == 0, i % 8 == 7, 32'hA000 + i});

        // Test 4: single-word bursts carry both flags with a bubble between
        load_length = 3'd0;
        load_depth = 3'd1;
        do_reset();
        push(32'h40);
        push(32'h41);
        chk("t4_w0", {30'b0, out_vld, out_fst, out_lst, out_data}, {30'b0, 3'b111, 32'h40});
        chk("t4_occ2", 64'(occupancy), 2);
        @(negedge clk);
        chk("t4_bubble_vld", 64'(out_vld), 0);
        chk("t4_bubble_busy", 64'(tx_busy), 0);
        chk("t4_occ1", 64'(occupancy), 1);
        @(negedge clk);
        chk("t4_w1", {30'b0, out_vld, out_fst, out_lst, out_data}, {30'b0, 3'b111, 32'h41});
        @(negedge clk);
        chk("t4_end_vld", 64'(out_vld), 0);
        chk("t4_end_occ", 64'(occupancy), 0);

        // Test 5: ten back-to-back bursts wrapping three slots
        load_length = 3'd1;
        load_depth = 3'd2;
        do_reset();
        b0 = both_cnt;
        for (int i = 0; i < 20; i++) push(32'h50 + i);
        wait_empty("t5_drain");
        chk("t5_simul_seen", 64'(both_cnt > b0), 1);
        chk("t5_count", 64'(q.size()), 20);
        for (int i = 0; i < 20; i++)
            chk("t5_word", 64'(q[i]), {30'b0, i % 2 == 0, i % 2 == 1, 32'h50 + i});

        // Test 6: reset in the middle of a burst, then a clean burst
        load_length = 3'd3;
        load_depth = 3'd1;
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h60 + i);
        repeat (3) @(negedge clk);
        chk("t6_mid_data", 64'(out_data), 32'h62);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_vld", 64'(out_vld), 0);
        chk("t6_rst_occ", 64'(occupancy), 0);
        chk("t6_rst_rdy", 64'(result_rdy), 1);
        chk("t6_rst_busy", 64'(tx_busy), 0);
        reset = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) push(32'h70 + i);
        wait_empty("t6_drain");
        chk("t6_count", 64'(q.size()), 4);
        for (int i = 0; i < 4; i++)
            chk("t6_word", 64'(q[i]), {30'b0, i == 0, i == 3, 32'h70 + i});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
